// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA channel scheduler
package dma_pkg;
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
    localparam logic DIR_IO2MEM = 1'b0;
    localparam logic DIR_MEM2IO = 1'b1;
    localparam int AW_DEF = 13;
    localparam int CW_DEF = 16;
endpackage

// File: rtl/dma_rr_arb.sv
// dma_rr_arb: combinational round-robin picker starting after last_grant
module dma_rr_arb import dma_pkg::*; #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         elig,
    input  logic [$clog2(NCH)-1:0] last_grant,
    output logic                   valid,
    output logic [$clog2(NCH)-1:0] winner
);
    logic [$clog2(NCH)-1:0] idx;
    // scan from farthest to nearest so the channel closest after last_grant wins
    always_comb begin
        valid = 1'b0;
        winner = '0;
        idx = '0;
        for (int i = NCH; i >= 1; i--) begin
            idx = ($clog2(NCH))'((int'(last_grant) + i) % NCH);
            if (elig[idx]) begin
                valid = 1'b1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/dma_chan_sched.sv
// dma_chan_sched: multi-channel single-byte DMA scheduler with round-robin arbitration
module dma_chan_sched import dma_pkg::*; #(
    parameter int NCH = 4,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                   cl,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [CW-1:0]          cfg_cnt,
    input  logic                   cfg_dir,
    input  logic                   cfg_en,
    input  logic [NCH-1:0]         dreq,
    input  logic                   hlda,
    input  logic [NCH-1:0]         int_clr,
    output logic                   hrq,
    output logic [NCH-1:0]         dack,
    output logic [AW-1:0]          addr_out,
    output logic                   ior_n,
    output logic                   iow_n,
    output logic                   memr_n,
    output logic                   memw_n,
    output logic                   tc,
    output logic [NCH-1:0]         intr,
    output logic                   busy
);
    state_t state, nxt;
    logic [NCH-1:0] en, dir, elig;
    logic [AW-1:0] addr [NCH];
    logic [CW-1:0] cnt [NCH];
    logic [$clog2(NCH)-1:0] g, last, arb_win;
    logic arb_valid;

    // a channel competes only while enabled, requesting and holding bytes
    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++) elig[i] = en[i] & dreq[i] & (cnt[i] != '0);
    end

    dma_rr_arb #(.NCH(NCH)) u_arb (
        .elig(elig),
        .last_grant(last),
        .valid(arb_valid),
        .winner(arb_win)
    );

    // state register
    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end

    // next state: one byte per grant, REQ waits for hlda without timeout
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = arb_valid ? REQ : IDLE;
            REQ:  nxt = hlda ? XFER : REQ;
            XFER: nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    // channel registers, grant latch and sticky interrupts; writes to the active channel are dropped
    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            g <= '0;
            last <= ($clog2(NCH))'(NCH - 1);
            en <= '0;
            dir <= '0;
            intr <= '0;
            for (int i = 0; i < NCH; i++) begin
                addr[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            if (state == IDLE && arb_valid) g <= arb_win;
            intr <= intr & ~int_clr;
            if (cfg_we && int'(cfg_ch) < NCH && !(busy && cfg_ch == g)) begin
                addr[cfg_ch] <= cfg_addr;
                cnt[cfg_ch] <= cfg_cnt;
                dir[cfg_ch] <= cfg_dir;
                en[cfg_ch] <= cfg_en && (cfg_cnt != '0);
            end
            if (state == DONE) begin
                addr[g] <= addr[g] + 1'b1;
                cnt[g] <= cnt[g] - 1'b1;
                last <= g;
                if (cnt[g] == CW'(1)) begin
                    en[g] <= 1'b0;
                    intr[g] <= 1'b1;
                end
            end
        end
    end

    // bus outputs decoded from state so reset releases them immediately
    always_comb begin
        busy = state != IDLE;
        hrq = state == REQ || state == XFER;
        dack = (state == XFER) ? NCH'(1) << g : '0;
        addr_out = (state == XFER) ? addr[g] : '0;
        ior_n = !(state == XFER && dir[g] == DIR_IO2MEM);
        memw_n = !(state == XFER && dir[g] == DIR_IO2MEM);
        memr_n = !(state == XFER && dir[g] == DIR_MEM2IO);
        iow_n = !(state == XFER && dir[g] == DIR_MEM2IO);
        tc = state == DONE && cnt[g] == CW'(1);
    end
endmodule
